// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_ctrl_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned CODE_W       = 31;
  localparam int unsigned MTVEC_BASE_W = 30;

  localparam logic [CODE_W-1:0] IRQ_MSI = 31'd3;
  localparam logic [CODE_W-1:0] IRQ_MTI = 31'd7;
  localparam logic [CODE_W-1:0] IRQ_MEI = 31'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_WFI      = 3'd4
  } trap_state_t;

  typedef enum logic [1:0] {
    KIND_EXC  = 2'd0,
    KIND_IRQ  = 2'd1,
    KIND_MRET = 2'd2
  } trap_kind_t;

  // Trap vector: base for exceptions/direct mode, base + 4*code for vectored interrupts.
  function automatic logic [XLEN-1:0] trap_target(
    input logic [MTVEC_BASE_W-1:0] base,
    input logic [1:0]              mode,
    input trap_kind_t              kind,
    input logic [CODE_W-1:0]       code
  );
    logic [XLEN-1:0] base_addr;
    base_addr = {base, 2'b00};
    if ((kind == KIND_IRQ) && (mode == MTVEC_VECTORED)) begin
      return base_addr + (XLEN'(code) << 2);
    end
    return base_addr;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq.sv
// Multi-stage flop synchronizer for one asynchronous interrupt line.
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw level through the chain; cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, MRET and interrupts,
// drains the pipeline, strobes the CSR file and redirects fetch.
// Optional WFI sleep state is built when TRAP_CTRL_WFI_EN is defined.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    irq_ext,
  input  logic                    irq_timer,
  input  logic                    irq_soft,
  input  logic                    exc_valid,
  input  logic [CODE_W-1:0]       exc_cause,
  input  logic [XLEN-1:0]         exc_pc,
  input  logic                    mret_req,
  input  logic [XLEN-1:0]         commit_pc,
  input  logic                    pipe_drained,
  input  logic                    csr_interrupt_en,
  input  logic [XLEN-1:0]         csr_mie,
  input  logic [1:0]              csr_mtvec_mode,
  input  logic [MTVEC_BASE_W-1:0] csr_mtvec_base,
  input  logic [XLEN-1:0]         csr_mepc,
  output logic                    csr_exception,
  output logic [XLEN-1:0]         csr_exception_cause,
  output logic [XLEN-1:0]         csr_exception_pc,
  output logic                    csr_mret,
  output logic [XLEN-1:0]         irq_pending,
`ifdef TRAP_CTRL_WFI_EN
  input  logic                    wfi_req,
  output logic                    wfi_sleep,
`endif
  output logic                    trap_flush,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc
);

  logic mei_s, mti_s, msi_s;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext   (.clk(clk), .nrst(nrst), .d_i(irq_ext),   .q_o(mei_s));
  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_timer (.clk(clk), .nrst(nrst), .d_i(irq_timer), .q_o(mti_s));
  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_soft  (.clk(clk), .nrst(nrst), .d_i(irq_soft),  .q_o(msi_s));

  assign irq_pending = {20'd0, mei_s, 3'd0, mti_s, 3'd0, msi_s, 3'd0};

  trap_state_t       state_q, state_d;
  trap_kind_t        kind_q;
  logic [XLEN-1:0]   cause_q, epc_q, mret_pc_q, redirect_pc_q, redirect_pc_d;
  logic              exc_q, exc_d, mret_q, mret_d, flush_q, flush_d, redir_q, redir_d;
  logic              acc_exc, acc_mret, acc_irq;
  logic [XLEN-1:0]   pend_en;
  logic              irq_any, irq_take;
  logic [CODE_W-1:0] irq_code;
`ifdef TRAP_CTRL_WFI_EN
  logic              sleep_q, sleep_d;
`endif

  assign pend_en  = irq_pending & csr_mie;
  assign irq_any  = |pend_en;
  assign irq_take = csr_interrupt_en & irq_any;

  // Highest-priority enabled source: MEI > MSI > MTI.
  always_comb begin
    irq_code = IRQ_MTI;
    if (pend_en[11]) begin
      irq_code = IRQ_MEI;
    end else if (pend_en[3]) begin
      irq_code = IRQ_MSI;
    end
  end

  // Next-state, acceptance and registered-output next values.
  always_comb begin
    state_d       = state_q;
    acc_exc       = 1'b0;
    acc_mret      = 1'b0;
    acc_irq       = 1'b0;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          acc_exc = 1'b1;
          state_d = ST_DRAIN;
        end else if (mret_req) begin
          acc_mret = 1'b1;
          state_d  = ST_DRAIN;
        end else if (irq_take) begin
          acc_irq = 1'b1;
          state_d = ST_DRAIN;
`ifdef TRAP_CTRL_WFI_EN
        end else if (wfi_req) begin
          state_d = ST_WFI;
`endif
        end
      end
      ST_DRAIN: begin
        if (pipe_drained) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_REDIRECT;
        if (kind_q == KIND_MRET) begin
          redirect_pc_d = mret_pc_q & ~XLEN'(1);
        end else begin
          redirect_pc_d = trap_target(csr_mtvec_base, csr_mtvec_mode, kind_q, cause_q[CODE_W-1:0]);
        end
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
`ifdef TRAP_CTRL_WFI_EN
      ST_WFI: begin
        if (irq_any) state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    flush_d = (state_d != ST_IDLE);
    exc_d   = (state_d == ST_COMMIT) && (kind_q != KIND_MRET);
    mret_d  = (state_d == ST_COMMIT) && (kind_q == KIND_MRET);
    redir_d = (state_d == ST_REDIRECT);
`ifdef TRAP_CTRL_WFI_EN
    sleep_d = (state_d == ST_WFI);
`endif
  end

  // State and registered control outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q       <= ST_IDLE;
      flush_q       <= 1'b0;
      exc_q         <= 1'b0;
      mret_q        <= 1'b0;
      redir_q       <= 1'b0;
      redirect_pc_q <= '0;
`ifdef TRAP_CTRL_WFI_EN
      sleep_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      flush_q       <= flush_d;
      exc_q         <= exc_d;
      mret_q        <= mret_d;
      redir_q       <= redir_d;
      redirect_pc_q <= redirect_pc_d;
`ifdef TRAP_CTRL_WFI_EN
      sleep_q       <= sleep_d;
`endif
    end
  end

  // Capture the accepted request; the cause is final once latched.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      kind_q    <= KIND_EXC;
      cause_q   <= '0;
      epc_q     <= '0;
      mret_pc_q <= '0;
    end else if (acc_exc) begin
      kind_q  <= KIND_EXC;
      cause_q <= {1'b0, exc_cause};
      epc_q   <= exc_pc;
    end else if (acc_mret) begin
      kind_q    <= KIND_MRET;
      mret_pc_q <= csr_mepc;
    end else if (acc_irq) begin
      kind_q  <= KIND_IRQ;
      cause_q <= {1'b1, irq_code};
      epc_q   <= commit_pc;
    end
  end

  assign csr_exception       = exc_q;
  assign csr_exception_cause = cause_q;
  assign csr_exception_pc    = epc_q;
  assign csr_mret            = mret_q;
  assign trap_flush          = flush_q;
  assign redirect_valid      = redir_q;
  assign redirect_pc         = redirect_pc_q;
`ifdef TRAP_CTRL_WFI_EN
  assign wfi_sleep           = sleep_q;
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl (default build).
`timescale 1ns/1ps
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        irq_ext, irq_timer, irq_soft;
  logic        exc_valid;
  logic [30:0] exc_cause;
  logic [31:0] exc_pc;
  logic        mret_req;
  logic [31:0] commit_pc;
  logic        pipe_drained;
  logic        csr_interrupt_en;
  logic [31:0] csr_mie;
  logic [1:0]  csr_mtvec_mode;
  logic [29:0] csr_mtvec_base;
  logic [31:0] csr_mepc;
  logic        csr_exception;
  logic [31:0] csr_exception_cause, csr_exception_pc;
  logic        csr_mret;
  logic [31:0] irq_pending;
  logic        trap_flush, redirect_valid;
  logic [31:0] redirect_pc;
`ifdef TRAP_CTRL_WFI_EN
  logic        wfi_req = 1'b0;
  logic        wfi_sleep;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  trap_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .nrst(nrst),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_req(mret_req), .commit_pc(commit_pc), .pipe_drained(pipe_drained),
    .csr_interrupt_en(csr_interrupt_en), .csr_mie(csr_mie),
    .csr_mtvec_mode(csr_mtvec_mode), .csr_mtvec_base(csr_mtvec_base), .csr_mepc(csr_mepc),
    .csr_exception(csr_exception), .csr_exception_cause(csr_exception_cause),
    .csr_exception_pc(csr_exception_pc), .csr_mret(csr_mret), .irq_pending(irq_pending),
`ifdef TRAP_CTRL_WFI_EN
    .wfi_req(wfi_req), .wfi_sleep(wfi_sleep),
`endif
    .trap_flush(trap_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // {trap_flush, csr_exception, csr_mret, redirect_valid}
  function automatic logic [3:0] status();
    return {trap_flush, csr_exception, csr_mret, redirect_valid};
  endfunction

  task automatic test_reset();
    logic [131:0] all_out;
    nrst = 1'b0;
    tick(); tick();
    all_out = {csr_exception, csr_exception_cause, csr_exception_pc, csr_mret,
               irq_pending, trap_flush, redirect_valid, redirect_pc};
    tests_run++;
    if (all_out !== '0) begin tests_failed++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    nrst = 1'b1;
    tick();
    tests_run++;
    if (status() !== 4'b0000) begin tests_failed++; $display("FAIL reset_release_status: got %b want 0000", status()); end
  endtask

  task automatic test_direct_exc();
    csr_mtvec_mode = 2'd0; pipe_drained = 1'b1;
    exc_valid = 1'b1; exc_cause = 31'd2; exc_pc = 32'h100;
    tick();
    exc_valid = 1'b0;
    tests_run++;
    if (status() !== 4'b1000) begin tests_failed++; $display("FAIL dexc_drain: got %b want 1000", status()); end
    tick();
    tests_run++;
    if (status() !== 4'b1100) begin tests_failed++; $display("FAIL dexc_commit: got %b want 1100", status()); end
    tests_run++;
    if (csr_exception_cause !== 32'h2) begin tests_failed++; $display("FAIL dexc_cause: got %h want 00000002", csr_exception_cause); end
    tests_run++;
    if (csr_exception_pc !== 32'h100) begin tests_failed++; $display("FAIL dexc_pc: got %h want 00000100", csr_exception_pc); end
    tick();
    tests_run++;
    if (status() !== 4'b1001) begin tests_failed++; $display("FAIL dexc_redir: got %b want 1001", status()); end
    tests_run++;
    if (redirect_pc !== 32'h8000) begin tests_failed++; $display("FAIL dexc_target: got %h want 00008000", redirect_pc); end
    tick();
    tests_run++;
    if (status() !== 4'b0000) begin tests_failed++; $display("FAIL dexc_idle: got %b want 0000", status()); end
  endtask

  task automatic test_vectored_timer();
    csr_mtvec_mode = 2'd1; csr_interrupt_en = 1'b1; csr_mie = 32'h80;
    commit_pc = 32'h240; irq_timer = 1'b1;
    tick();
    tests_run++;
    if (irq_pending !== 32'h0) begin tests_failed++; $display("FAIL tmr_sync1: got %h want 0", irq_pending); end
    tick();
    tests_run++;
    if (irq_pending !== 32'h80) begin tests_failed++; $display("FAIL tmr_sync2: got %h want 00000080", irq_pending); end
    tests_run++;
    if (status() !== 4'b0000) begin tests_failed++; $display("FAIL tmr_not_yet: got %b want 0000", status()); end
    tick();
    irq_timer = 1'b0;
    tests_run++;
    if (status() !== 4'b1000) begin tests_failed++; $display("FAIL tmr_drain: got %b want 1000", status()); end
    tick();
    tests_run++;
    if (status() !== 4'b1100) begin tests_failed++; $display("FAIL tmr_commit: got %b want 1100", status()); end
    tests_run++;
    if (csr_exception_cause !== 32'h80000007) begin tests_failed++; $display("FAIL tmr_cause: got %h want 80000007", csr_exception_cause); end
    tests_run++;
    if (csr_exception_pc !== 32'h240) begin tests_failed++; $display("FAIL tmr_pc: got %h want 00000240", csr_exception_pc); end
    tick();
    tests_run++;
    if (redirect_pc !== 32'h801C || redirect_valid !== 1'b1) begin tests_failed++; $display("FAIL tmr_target: got %h/%b want 0000801c/1", redirect_pc, redirect_valid); end
    tick();
  endtask

  task automatic test_irq_masked();
    csr_interrupt_en = 1'b0; csr_mie = 32'h80; irq_timer = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (irq_pending !== 32'h80) begin tests_failed++; $display("FAIL mask_pending: got %h want 00000080", irq_pending); end
    tests_run++;
    if (status() !== 4'b0000) begin tests_failed++; $display("FAIL mask_no_trap: got %b want 0000", status()); end
    irq_timer = 1'b0;
    tick(); tick(); tick();
    tests_run++;
    if (irq_pending !== 32'h0) begin tests_failed++; $display("FAIL mask_clear: got %h want 0", irq_pending); end
    csr_interrupt_en = 1'b1;
  endtask

  task automatic test_irq_priority();
    csr_mtvec_mode = 2'd1; csr_mie = 32'h888; commit_pc = 32'h248;
    irq_ext = 1'b1; irq_timer = 1'b1;
    tick(); tick();
    tests_run++;
    if (irq_pending !== 32'h880) begin tests_failed++; $display("FAIL prio_pending: got %h want 00000880", irq_pending); end
    tick();
    irq_ext = 1'b0; irq_timer = 1'b0;
    tick();
    tests_run++;
    if (csr_exception !== 1'b1 || csr_exception_cause !== 32'h8000000B) begin tests_failed++; $display("FAIL prio_cause: got %b/%h want 1/8000000b", csr_exception, csr_exception_cause); end
    tick();
    tests_run++;
    if (redirect_pc !== 32'h802C) begin tests_failed++; $display("FAIL prio_target: got %h want 0000802c", redirect_pc); end
    tick();
  endtask

  task automatic test_exc_over_irq();
    csr_mtvec_mode = 2'd1; csr_mie = 32'h888;
    irq_ext = 1'b1; irq_timer = 1'b1;
    tick(); tick();
    exc_valid = 1'b1; exc_cause = 31'd5; exc_pc = 32'h300;
    tick();
    exc_valid = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0;
    tick();
    tests_run++;
    if (csr_exception !== 1'b1 || csr_exception_cause !== 32'h5) begin tests_failed++; $display("FAIL exirq_cause: got %b/%h want 1/00000005", csr_exception, csr_exception_cause); end
    tests_run++;
    if (csr_exception_pc !== 32'h300) begin tests_failed++; $display("FAIL exirq_pc: got %h want 00000300", csr_exception_pc); end
    tick();
    tests_run++;
    if (redirect_pc !== 32'h8000) begin tests_failed++; $display("FAIL exirq_target: got %h want 00008000", redirect_pc); end
    tick();
  endtask

  task automatic test_mret();
    csr_mepc = 32'h104; mret_req = 1'b1;
    tick();
    mret_req = 1'b0;
    tick();
    tests_run++;
    if (status() !== 4'b1010) begin tests_failed++; $display("FAIL mret_commit: got %b want 1010", status()); end
    tests_run++;
    if (csr_exception_cause !== 32'h5) begin tests_failed++; $display("FAIL mret_cause_hold: got %h want 00000005", csr_exception_cause); end
    tick();
    tests_run++;
    if (redirect_pc !== 32'h104 || status() !== 4'b1001) begin tests_failed++; $display("FAIL mret_target: got %h/%b want 00000104/1001", redirect_pc, status()); end
    tick();
    csr_mepc = 32'h20B; mret_req = 1'b1;
    tick();
    mret_req = 1'b0;
    tick(); tick();
    tests_run++;
    if (redirect_pc !== 32'h20A) begin tests_failed++; $display("FAIL mret_bit0: got %h want 0000020a", redirect_pc); end
    tick();
  endtask

  task automatic test_mret_vs_exc();
    csr_mtvec_mode = 2'd0; csr_mepc = 32'h104;
    mret_req = 1'b1; exc_valid = 1'b1; exc_cause = 31'd1; exc_pc = 32'h400;
    tick();
    mret_req = 1'b0; exc_valid = 1'b0;
    tick();
    tests_run++;
    if (status() !== 4'b1100 || csr_exception_cause !== 32'h1) begin tests_failed++; $display("FAIL mvse_commit: got %b/%h want 1100/00000001", status(), csr_exception_cause); end
    tick();
    tests_run++;
    if (redirect_pc !== 32'h8000) begin tests_failed++; $display("FAIL mvse_target: got %h want 00008000", redirect_pc); end
    tick();
  endtask

  task automatic test_drain_stall();
    csr_mtvec_mode = 2'd0; pipe_drained = 1'b0;
    exc_valid = 1'b1; exc_cause = 31'd4; exc_pc = 32'h500;
    tick();
    exc_cause = 31'd9; exc_pc = 32'h600;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (status() !== 4'b1000) begin tests_failed++; $display("FAIL stall_%0d: got %b want 1000", i, status()); end
    end
    exc_valid = 1'b0; pipe_drained = 1'b1;
    tick();
    tests_run++;
    if (status() !== 4'b1100 || csr_exception_cause !== 32'h4 || csr_exception_pc !== 32'h500) begin
      tests_failed++; $display("FAIL stall_commit: got %b/%h/%h want 1100/00000004/00000500", status(), csr_exception_cause, csr_exception_pc);
    end
    tick(); tick();
    tests_run++;
    if (status() !== 4'b0000) begin tests_failed++; $display("FAIL stall_idle: got %b want 0000", status()); end
  endtask

  task automatic test_reset_mid_drain();
    logic [131:0] all_out;
    pipe_drained = 1'b0; exc_valid = 1'b1; exc_cause = 31'd6; exc_pc = 32'h700;
    tick();
    exc_valid = 1'b0; nrst = 1'b0;
    irq_ext = 1'b1; irq_timer = 1'b1; irq_soft = 1'b1;
    tick();
    all_out = {csr_exception, csr_exception_cause, csr_exception_pc, csr_mret,
               irq_pending, trap_flush, redirect_valid, redirect_pc};
    tests_run++;
    if (all_out !== '0) begin tests_failed++; $display("FAIL rstmid_outputs: got %h want 0", all_out); end
    tick();
    tests_run++;
    if (irq_pending !== 32'h0) begin tests_failed++; $display("FAIL rstmid_pending: got %h want 0", irq_pending); end
    irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
    nrst = 1'b1; pipe_drained = 1'b1;
    tick();
    tests_run++;
    if (status() !== 4'b0000 || csr_exception_cause !== 32'h0) begin tests_failed++; $display("FAIL rstmid_after: got %b/%h want 0000/0", status(), csr_exception_cause); end
    tick();
    tests_run++;
    if (status() !== 4'b0000) begin tests_failed++; $display("FAIL rstmid_after2: got %b want 0000", status()); end
  endtask

  initial begin
    nrst = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; mret_req = 1'b0;
    commit_pc = '0; pipe_drained = 1'b1; csr_interrupt_en = 1'b0; csr_mie = '0;
    csr_mtvec_mode = 2'd0; csr_mtvec_base = 30'h2000; csr_mepc = '0;
    test_reset();
    test_direct_exc();
    test_vectored_timer();
    test_irq_masked();
    test_irq_priority();
    test_exc_over_irq();
    test_mret();
    test_mret_vs_exc();
    test_drain_stall();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap sequencer that is the producing side of the CSR file's trap interface. It gathers synchronous exceptions, MRET requests and the three machine interrupt lines (external, timer, software), and arbitrates between them. It then drains the pipeline, pulses the CSR file's exception or MRET strobes, and redirects fetch to the trap vector or to MEPC. It sits between the core pipeline (execute/commit, fetch) and the CSR file.

Parameters:
SYNC_STAGES, 2, number of flip-flop synchronizer stages on each asynchronous IRQ input (minimum 2).

Ports:
clk  in  1  clock
nrst  in  1  reset; nrst is synchronous and active-low on clk
irq_ext  in  1  machine external interrupt line (asynchronous, level)
irq_timer  in  1  machine timer interrupt line (asynchronous, level)
irq_soft  in  1  machine software interrupt line (asynchronous, level)
exc_valid  in  1  synchronous exception raised by the oldest instruction
exc_cause  in  31  exception code
exc_pc  in  32  PC of the faulting instruction
mret_req  in  1  MRET is at commit
commit_pc  in  32  PC of the oldest uncommitted instruction, used as MEPC for interrupts
pipe_drained  in  1  pipeline empty/flushed acknowledge
csr_interrupt_en  in  1  mstatus.MIE
csr_mie  in  32  MIE register
csr_mtvec_mode  in  2  0 = direct, 1 = vectored, 2 and 3 treated as direct
csr_mtvec_base  in  30  trap base, word address
csr_mepc  in  32  current MEPC
csr_exception  out  1  one-cycle trap-entry strobe to the CSR file
csr_exception_cause  out  32  mcause value; bit 31 = interrupt
csr_exception_pc  out  32  mepc value
csr_mret  out  1  one-cycle MRET strobe to the CSR file
irq_pending  out  32  synchronized pending bits: [11]=MEI, [7]=MTI, [3]=MSI, all other bits 0
trap_flush  out  1  stall fetch and flush the pipeline
redirect_valid  out  1  one-cycle fetch redirect
redirect_pc  out  32  redirect target

Behaviour:
- Reset (nrst low at a clk edge):
  - State returns to IDLE. Synchronizers and latched cause, pc and kind are cleared.
  - All outputs are 0. This applies mid-sequence too; no strobe may fire during the cycle after reset.
- IRQ inputs pass through SYNC_STAGES flops before use, so irq_pending lags the pins by SYNC_STAGES cycles.
- Interrupt taken condition: csr_interrupt_en & |(irq_pending & csr_mie).
- States and transitions:
  - IDLE: requests are accepted only here, with priority exc_valid > mret_req > interrupt.
    - Exception: latch {0, exc_cause} and exc_pc.
    - MRET: latch csr_mepc as the target.
    - Interrupt: latch the highest-priority enabled pending source (MEI 11 > MSI 3 > MTI 7) as {1, code}, and latch commit_pc.
    - On any accept, go to DRAIN.
  - DRAIN: trap_flush = 1. Stay here until pipe_drained = 1, then go to COMMIT.
  - COMMIT: trap_flush = 1. Pulse csr_exception with the latched cause/pc, or csr_mret for MRET. Go to REDIRECT.
  - REDIRECT: trap_flush = 1, redirect_valid = 1, then go to IDLE.
- Latency: accept edge → COMMIT strobe in 2 cycles → redirect in 3 cycles (minimum, when pipe_drained is high in the first DRAIN cycle).
- Requests arriving outside IDLE are ignored. The pipeline re-presents them after the redirect.
- redirect_pc, registered in COMMIT:
  - Exception, or direct mode: {base, 2'b00}.
  - Vectored mode and interrupt: {base, 2'b00} + 4 × code, 32-bit wrap.
  - MRET: latched MEPC with bit 0 cleared.
- csr_exception_cause/pc hold their latched values while not strobing, and are 0 after reset.
- An interrupt that deasserts after acceptance is still taken; the latched cause is final.

Optional Feature:
TRAP_CTRL_WFI_EN
- Enabled:
  - Adds input wfi_req and output wfi_sleep.
  - A wfi_req accepted in IDLE (lowest priority) enters state WFI with wfi_sleep = 1 and trap_flush = 1.
  - WFI exits to IDLE when |(irq_pending & csr_mie), independent of csr_interrupt_en. The interrupt is then evaluated normally.
  - Reset exits WFI.
- Disabled: these ports and the WFI state do not exist.

Decomposition:
- Shared package: trap_state_t enum (IDLE, DRAIN, COMMIT, REDIRECT, WFI), trap_kind_t (EXC, IRQ, MRET), cause constants IRQ_MSI=3, IRQ_MTI=7, IRQ_MEI=11, MTVEC_DIRECT=0, MTVEC_VECTORED=1.
- Sub-module: irq_sync, a parameterised SYNC_STAGES-deep single-bit synchronizer, instantiated three times.

Test Plan:
- Reset check: hold nrst low during DRAIN with the IRQ pins high → all outputs 0, state IDLE.
- Direct-mode exception: exc_valid, cause 2, exc_pc 0x100, base 0x2000, mode 0, pipe_drained=1 → csr_exception at +2 with cause 0x00000002, pc 0x100; redirect_pc 0x8000 at +3.
- Vectored timer interrupt: irq_timer=1, mie[7]=1, MIE=1, mode 1, commit_pc 0x240 → after 2 sync cycles, cause 0x80000007, pc 0x240, redirect_pc 0x801C. With MIE=0 → no trap.
- Interrupt priority and ordering: irq_ext and irq_timer together → cause 0x8000000B, redirect_pc 0x802C. exc_valid with the same sources pending → the exception is taken.
- MRET: mret_req with csr_mepc 0x104 → csr_mret pulse, redirect_pc 0x104, csr_exception stays 0. Simultaneous exc_valid → the exception wins.
- Drain stall: pipe_drained held low 5 cycles → trap_flush high, no strobes, new exc_valid ignored; strobe fires on the cycle after pipe_drained rises.
